// File: rtl/scariv_lsu_pkg.sv
// Shared sizes and pointer/count types for the LSU issue queue and its controller.
package scariv_lsu_pkg;

  localparam int LSU_ISS_ENTRY_SIZE = 16;
  localparam int LSU_DISP_SIZE      = 2;
  localparam int LSU_IQ_PTR_W       = $clog2(LSU_ISS_ENTRY_SIZE);

  typedef logic [LSU_IQ_PTR_W-1:0] lsu_iq_ptr_t;
  typedef logic [LSU_IQ_PTR_W:0]   lsu_iq_cnt_t;

  // Lane index width; a single-lane dispatch still gets a 1-bit field.
  function automatic int lsu_lane_w(input int disp_size);
    return (disp_size > 1) ? $clog2(disp_size) : 1;
  endfunction

endpackage

// File: rtl/scariv_lsu_age_picker.sv
// Age-ordered find-first: rotates the request vector so base lands at bit 0,
// finds the lowest set bit, and reports its distance from base.
module scariv_lsu_age_picker #(
  parameter  int N = 16,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] base,
  output logic         found,
  output logic [W-1:0] offset
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  always_comb begin
    dbl    = {req, req} >> base;
    rot    = dbl[N-1:0];
    found  = 1'b0;
    offset = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found  = 1'b1;
        offset = W'(i);
      end
    end
  end

endmodule

// File: rtl/scariv_lsu_issue_ctrl.sv
// Queue-side controller of the LSU scheduler: in-order allocation, oldest-first
// single pick per cycle, and in-order retirement of up to DISP_SIZE done entries.
module scariv_lsu_issue_ctrl
  import scariv_lsu_pkg::*;
#(
  parameter  int ENTRY_SIZE = LSU_ISS_ENTRY_SIZE,
  parameter  int DISP_SIZE  = LSU_DISP_SIZE,
  localparam int PTR_W      = $clog2(ENTRY_SIZE),
  localparam int CNT_W      = PTR_W + 1,
  localparam int LANE_W     = lsu_lane_w(DISP_SIZE)
) (
  input  logic                               i_clk,
  input  logic                               i_reset_n,
  input  logic [DISP_SIZE-1:0]               i_disp_valid,
  output logic                               o_disp_ready,
  output logic [ENTRY_SIZE-1:0]              o_entry_put,
  output logic [ENTRY_SIZE-1:0][LANE_W-1:0]  o_entry_lane,
  input  logic [ENTRY_SIZE-1:0]              i_entry_valid,
  input  logic [ENTRY_SIZE-1:0]              i_entry_ready,
  input  logic [ENTRY_SIZE-1:0]              i_entry_done,
  output logic [ENTRY_SIZE-1:0]              o_entry_picked,
  output logic [ENTRY_SIZE-1:0]              o_entry_clear,
  output logic [ENTRY_SIZE-1:0]              o_entry_out_ptr_valid,
  output logic                               o_issue_valid,
  output logic [PTR_W-1:0]                   o_issue_idx,
  output logic [CNT_W-1:0]                   o_free_count
);

  logic [PTR_W-1:0]      r_in_ptr;
  logic [PTR_W-1:0]      r_out_ptr;
  logic [CNT_W-1:0]      r_count;

  logic                  accept;
  logic [CNT_W-1:0]      put_num;
  logic [PTR_W-1:0]      put_slot;
  logic [ENTRY_SIZE-1:0] pick_req;
  logic                  pick_found;
  logic [PTR_W-1:0]      pick_offset;
  logic [ENTRY_SIZE-1:0] ret_req;
  logic                  ret_found;
  logic [PTR_W-1:0]      ret_offset;
  logic [CNT_W-1:0]      run;
  logic [PTR_W-1:0]      clr_slot;

  // Dispatch handshake: a group is taken in any cycle where some lane of
  // i_disp_valid is high and o_disp_ready is high. Ready comes from registered
  // occupancy only, so dispatch may make valid depend on ready without a loop.
  assign o_free_count = CNT_W'(ENTRY_SIZE) - r_count;
  assign o_disp_ready = o_free_count >= CNT_W'(DISP_SIZE);
  assign accept       = (|i_disp_valid) & o_disp_ready;

  always_comb begin
    o_entry_put  = '0;
    o_entry_lane = '0;
    put_num      = '0;
    put_slot     = '0;
    for (int k = 0; k < DISP_SIZE; k++) begin
      if (accept && i_disp_valid[k]) begin
        put_slot               = r_in_ptr + PTR_W'(k);
        o_entry_put[put_slot]  = 1'b1;
        o_entry_lane[put_slot] = LANE_W'(k);
        put_num                = put_num + CNT_W'(1);
      end
    end
  end

  assign pick_req = i_entry_valid & i_entry_ready & ~o_entry_put;

  scariv_lsu_age_picker #(.N(ENTRY_SIZE)) u_pick (
    .req    (pick_req),
    .base   (r_out_ptr),
    .found  (pick_found),
    .offset (pick_offset)
  );

  assign o_issue_valid  = pick_found;
  assign o_issue_idx    = r_out_ptr + pick_offset;
  assign o_entry_picked = pick_found ? (ENTRY_SIZE'(1) << o_issue_idx) : '0;

  // The retire run ends at the first entry (from the head) that is not done,
  // so search for the first zero of valid&done.
  assign ret_req = ~(i_entry_valid & i_entry_done);

  scariv_lsu_age_picker #(.N(ENTRY_SIZE)) u_retire (
    .req    (ret_req),
    .base   (r_out_ptr),
    .found  (ret_found),
    .offset (ret_offset)
  );

  always_comb begin
    if (!ret_found || ({1'b0, ret_offset} >= CNT_W'(DISP_SIZE))) begin
      run = CNT_W'(DISP_SIZE);
    end else begin
      run = {1'b0, ret_offset};
    end
    o_entry_clear = '0;
    clr_slot      = '0;
    for (int k = 0; k < DISP_SIZE; k++) begin
      if (CNT_W'(k) < run) begin
        clr_slot                = r_out_ptr + PTR_W'(k);
        o_entry_clear[clr_slot] = 1'b1;
      end
    end
  end

  assign o_entry_out_ptr_valid = ENTRY_SIZE'(1) << r_out_ptr;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_in_ptr  <= '0;
      r_out_ptr <= '0;
      r_count   <= '0;
    end else begin
      r_in_ptr  <= r_in_ptr + put_num[PTR_W-1:0];
      r_out_ptr <= r_out_ptr + run[PTR_W-1:0];
      r_count   <= r_count + put_num - run;
    end
  end

  always @(posedge i_clk) begin
    if (i_reset_n) begin
      assert ((o_entry_put & i_entry_valid) == '0);
      assert (r_count <= CNT_W'(ENTRY_SIZE));
      assert ($onehot0(o_entry_picked));
    end
  end

endmodule

// File: tb/tb_scariv_lsu_issue_ctrl.sv
// Bench for scariv_lsu_issue_ctrl: directed scenarios plus random traffic, all
// checked against a program-order queue model of the scheduler occupancy.
module tb_scariv_lsu_issue_ctrl;
  import scariv_lsu_pkg::*;

  localparam int N = LSU_ISS_ENTRY_SIZE;
  localparam int D = LSU_DISP_SIZE;

  logic             clk = 1'b0;
  logic             i_reset_n = 1'b0;
  logic [D-1:0]     i_disp_valid = '0;
  logic             o_disp_ready;
  logic [N-1:0]     o_entry_put;
  logic [N-1:0][0:0] o_entry_lane;
  logic [N-1:0]     i_entry_valid = '0;
  logic [N-1:0]     i_entry_ready = '0;
  logic [N-1:0]     i_entry_done = '0;
  logic [N-1:0]     o_entry_picked;
  logic [N-1:0]     o_entry_clear;
  logic [N-1:0]     o_entry_out_ptr_valid;
  logic             o_issue_valid;
  lsu_iq_ptr_t      o_issue_idx;
  lsu_iq_cnt_t      o_free_count;

  scariv_lsu_issue_ctrl dut (
    .i_clk                 (clk),
    .i_reset_n             (i_reset_n),
    .i_disp_valid          (i_disp_valid),
    .o_disp_ready          (o_disp_ready),
    .o_entry_put           (o_entry_put),
    .o_entry_lane          (o_entry_lane),
    .i_entry_valid         (i_entry_valid),
    .i_entry_ready         (i_entry_ready),
    .i_entry_done          (i_entry_done),
    .o_entry_picked        (o_entry_picked),
    .o_entry_clear         (o_entry_clear),
    .o_entry_out_ptr_valid (o_entry_out_ptr_valid),
    .o_issue_valid         (o_issue_valid),
    .o_issue_idx           (o_issue_idx),
    .o_free_count          (o_free_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state: occupied entries in program order, plus allocation/head positions
  logic [3:0] exp_q[$];
  int         m_in = 0;
  int         m_out = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  logic [N-1:0] last_put, last_pick, last_clear, last_opv;
  logic         last_ready, last_iv;
  int           last_idx, last_free;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    i_reset_n    = 1'b0;
    i_disp_valid = '0;
    @(posedge clk);
    #1;
    i_reset_n = 1'b1;
    exp_q.delete();
    m_in  = 0;
    m_out = 0;
  endtask

  // One cycle: drive dispatch and entry status, compare all outputs with the model, advance it.
  task automatic step(input logic [D-1:0] dv, input logic [N-1:0] rdy, input logic [N-1:0] dn);
    logic [N-1:0] vmask, e_put, e_pick, e_clear;
    int           e_lane[N];
    int           cnt, npush, nret, e_idx;
    logic         e_ready, e_iv;
    vmask = '0;
    foreach (exp_q[i]) vmask[exp_q[i]] = 1'b1;
    i_disp_valid  = dv;
    i_entry_valid = vmask;
    i_entry_ready = rdy & vmask;
    i_entry_done  = dn & vmask;

    cnt     = exp_q.size();
    e_ready = (N - cnt) >= D;
    e_put   = '0;
    npush   = 0;
    for (int e = 0; e < N; e++) e_lane[e] = 0;
    if (dv != 0 && e_ready) begin
      for (int k = 0; k < D; k++) begin
        if (dv[k]) begin
          e_put[(m_in + k) % N]  = 1'b1;
          e_lane[(m_in + k) % N] = k;
          npush++;
        end
      end
    end
    e_iv   = 1'b0;
    e_idx  = 0;
    e_pick = '0;
    foreach (exp_q[i]) begin
      if (!e_iv && rdy[exp_q[i]]) begin
        e_iv   = 1'b1;
        e_idx  = int'(exp_q[i]);
        e_pick[exp_q[i]] = 1'b1;
      end
    end
    nret    = 0;
    e_clear = '0;
    while (nret < D && nret < cnt && dn[exp_q[nret]]) begin
      e_clear[exp_q[nret]] = 1'b1;
      nret++;
    end

    @(negedge clk);
    check("disp_ready", o_disp_ready, e_ready);
    check("free_count", o_free_count, N - cnt);
    check("out_ptr_valid", o_entry_out_ptr_valid, N'(1) << m_out);
    check("put", o_entry_put, e_put);
    for (int e = 0; e < N; e++)
      if (e_put[e]) check("lane", o_entry_lane[e], e_lane[e]);
    check("issue_valid", o_issue_valid, e_iv);
    check("picked", o_entry_picked, e_pick);
    if (e_iv) check("issue_idx", o_issue_idx, e_idx);
    check("clear", o_entry_clear, e_clear);

    last_put   = o_entry_put;
    last_pick  = o_entry_picked;
    last_clear = o_entry_clear;
    last_opv   = o_entry_out_ptr_valid;
    last_ready = o_disp_ready;
    last_iv    = o_issue_valid;
    last_idx   = int'(o_issue_idx);
    last_free  = int'(o_free_count);

    repeat (nret) void'(exp_q.pop_front());
    for (int k = 0; k < npush; k++) exp_q.push_back(4'((m_in + k) % N));
    m_in  = (m_in + npush) % N;
    m_out = (m_out + nret) % N;
    @(posedge clk);
    #1;
  endtask

  logic [D-1:0] rdv;
  logic [N-1:0] rr, rd;

  initial begin
    do_reset();

    // idle after reset
    repeat (8) step('0, '0, '0);
    check("rst_free", last_free, 16);
    check("rst_opv", last_opv, 16'h0001);
    check("rst_ready", last_ready, 1'b1);
    check("rst_strobes", {last_put, last_pick, last_clear}, '0);

    // fill all 16 entries two lanes at a time, then an ignored extra group
    for (int c = 0; c < 8; c++) begin
      step(2'b11, '0, '0);
      check("fill_put", last_put, 16'h3 << (2 * c));
    end
    step(2'b11, '0, '0);
    check("full_ready", last_ready, 1'b0);
    check("full_free", last_free, 0);
    check("full_noput", last_put, '0);

    // move head to 4, refill 0..3, then oldest-first picks with wrap
    step('0, '0, 16'h0003);
    step('0, '0, 16'h000C);
    step(2'b11, '0, '0);
    step(2'b11, '0, '0);
    step('0, 16'h0228, '0);
    check("pick5", last_idx, 5);
    step('0, 16'h0208, '0);
    check("pick9", last_idx, 9);
    step('0, 16'h0008, '0);
    check("pick3", last_idx, 3);
    check("pick3_vec", last_pick, 16'h0008);

    // strict in-order retire, capped at two per cycle
    do_reset();
    step(2'b11, '0, '0);
    step(2'b11, '0, '0);
    step('0, '0, 16'h0006);
    check("ret_blocked", last_clear, '0);
    step('0, '0, 16'h0007);
    check("ret_cap", last_clear, 16'h0003);
    step('0, '0, 16'h0004);
    check("ret_next", last_clear, 16'h0004);

    // one slot free: dispatch held, two retire, next cycle three free and ready
    do_reset();
    repeat (7) step(2'b11, '0, '0);
    step(2'b01, '0, '0);
    step(2'b01, '0, 16'h0003);
    check("c15_noput", last_put, '0);
    check("c15_clear", last_clear, 16'h0003);
    step('0, '0, '0);
    check("c15_ready", last_ready, 1'b1);
    check("c15_free", last_free, 3);

    // random traffic
    do_reset();
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 3))
        0:       rdv = 2'b00;
        1:       rdv = 2'b01;
        default: rdv = 2'b11;
      endcase
      rr = N'($urandom() & $urandom());
      rd = N'($urandom() & $urandom());
      step(rdv, rr, rd);
    end

    // reset while ten entries are live and picking
    do_reset();
    repeat (5) step(2'b11, '0, '0);
    i_entry_ready = i_entry_valid;
    do_reset();
    step('0, '1, '0);
    check("mrst_free", last_free, 16);
    check("mrst_opv", last_opv, 16'h0001);
    check("mrst_strobes", {last_put, last_pick, last_clear, 15'd0, last_iv}, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
